// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: arbiter state encoding and index-width helper.
package xbar_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Index width for n items; a single item still needs one bit of storage.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Cyclic first-one finder: lowest-offset set bit of req, searching upward from ptr with wrap.
module rr_priority_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    always_comb begin
        int         j;
        logic [W-1:0] cand;
        // NOTE: every output and temporary gets a default first so no path leaves one unassigned (no latch).
        found = 1'b0;
        index = '0;
        j     = 0;
        cand  = '0;
        // Walk offsets high to low so the smallest offset from ptr is the last write and wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            cand = W'(j);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/wrr_burst_forward_arbiter.sv
// Per-slave weighted round-robin forward arbiter with burst locking; ARESETn is expected
// to be deassert-synchronised to ACLK upstream.
module wrr_burst_forward_arbiter
    import xbar_pkg::*;
#(
    parameter  int MASTERS      = 2,
    parameter  int SLAVES       = 2,
    parameter  int SLAVE_ID     = 0,
    parameter  int WEIGHT_W     = 4,
    parameter  int LOCK_BURST   = 1,
    localparam int MASTER_IDX_W = idx_w(MASTERS),
    localparam int SLAVE_IDX_W  = idx_w(SLAVES)
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETn,
    input  logic [MASTERS-1:0]                     master_fifo_empty,
    input  logic [MASTERS-1:0][SLAVE_IDX_W-1:0]    master_slave_dest,
    input  logic [MASTERS-1:0]                     master_last,
    input  logic [MASTERS-1:0][WEIGHT_W-1:0]       master_weight,
    input  logic                                   slave_fifo_full,
    output logic                                   grant_valid,
    output logic [MASTER_IDX_W-1:0]                grant_master_number,
    output logic [MASTERS-1:0]                     grant_onehot,
    output logic [MASTERS-1:0]                     master_pop
);

    arb_state_e              state;
    logic [MASTER_IDX_W-1:0] rr_ptr;
    logic [WEIGHT_W-1:0]     credit;
    logic                    cont_pending;

    logic [MASTERS-1:0]      req;
    logic                    pick_found;
    logic [MASTER_IDX_W-1:0] pick_index;
    logic [WEIGHT_W-1:0]     pick_weight;
    logic [WEIGHT_W-1:0]     first_credit;
    logic                    owner_req;
    logic                    pop_en;
    logic                    beat_end;
    logic                    release_now;
    logic [MASTER_IDX_W-1:0] next_ptr;

    always_comb begin
        req = '0;
        for (int i = 0; i < MASTERS; i++) begin
            req[i] = ~master_fifo_empty[i] & (master_slave_dest[i] == SLAVE_IDX_W'(SLAVE_ID));
        end
    end

    rr_priority_picker #(
        .N (MASTERS),
        .W (MASTER_IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_index)
    );

    // A zero weight still grants one transaction.
    assign pick_weight  = master_weight[pick_index];
    assign first_credit = (pick_weight == '0) ? '0 : pick_weight - WEIGHT_W'(1);

    assign owner_req  = req[grant_master_number];
    assign pop_en     = grant_valid & owner_req & ~slave_fifo_full;
    assign master_pop = pop_en ? grant_onehot : '0;
    assign beat_end   = pop_en & (master_last[grant_master_number] | (LOCK_BURST == 0));

    // After a credited transaction end, the owner keeps the slave only if it asks again next cycle.
    assign release_now = (state == ARB_GRANT)
                       & ((cont_pending & ~owner_req) | (beat_end & (credit == '0)));

    assign next_ptr = (grant_master_number == MASTER_IDX_W'(MASTERS - 1))
                    ? '0 : grant_master_number + MASTER_IDX_W'(1);

    // NOTE: non-blocking assignments for every register so all state updates see pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state               <= ARB_IDLE;
            grant_valid         <= 1'b0;
            grant_master_number <= '0;
            grant_onehot        <= '0;
            rr_ptr              <= '0;
            credit              <= '0;
            cont_pending        <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state               <= ARB_GRANT;
                        grant_valid         <= 1'b1;
                        grant_master_number <= pick_index;
                        grant_onehot        <= MASTERS'(1) << pick_index;
                        credit              <= first_credit;
                        cont_pending        <= 1'b0;
                    end
                end
                ARB_GRANT: begin
                    if (release_now) begin
                        state        <= ARB_IDLE;
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                        rr_ptr       <= next_ptr;
                        credit       <= '0;
                        cont_pending <= 1'b0;
                    end else if (beat_end) begin
                        // credit is non-zero here; a zero credit end is a release.
                        credit       <= credit - WEIGHT_W'(1);
                        cont_pending <= 1'b1;
                    end else begin
                        cont_pending <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_burst_forward_arbiter.sv
// Directed bench: MASTERS=3, SLAVES=2, SLAVE_ID=1; per-cycle vectors with hand-derived grant/pop values.
module tb_wrr_burst_forward_arbiter;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [2:0]      master_fifo_empty;
    logic [2:0][0:0] master_slave_dest;
    logic [2:0]      master_last;
    logic [2:0][3:0] master_weight;
    logic            slave_fifo_full;
    logic            grant_valid;
    logic [1:0]      grant_master_number;
    logic [2:0]      grant_onehot;
    logic [2:0]      master_pop;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    string scn   = "reset";

    wrr_burst_forward_arbiter #(
        .MASTERS    (3),
        .SLAVES     (2),
        .SLAVE_ID   (1),
        .WEIGHT_W   (4),
        .LOCK_BURST (1)
    ) dut (
        .ACLK                (ACLK),
        .ARESETn             (ARESETn),
        .master_fifo_empty   (master_fifo_empty),
        .master_slave_dest   (master_slave_dest),
        .master_last         (master_last),
        .master_weight       (master_weight),
        .slave_fifo_full     (slave_fifo_full),
        .grant_valid         (grant_valid),
        .grant_master_number (grant_master_number),
        .grant_onehot        (grant_onehot),
        .master_pop          (master_pop)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string where, input logic exp_gv, input int exp_own,
                                 input logic [2:0] exp_pop);
        logic [2:0] exp_oh;
        exp_oh = exp_gv ? (3'b001 << exp_own) : 3'b000;
        check($sformatf("%s grant_valid", where), 32'(grant_valid), 32'(exp_gv));
        if (exp_gv) check($sformatf("%s owner", where), 32'(grant_master_number), 32'(exp_own));
        check($sformatf("%s onehot", where), 32'(grant_onehot), 32'(exp_oh));
        check($sformatf("%s pop", where), 32'(master_pop), 32'(exp_pop));
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance past the next rising edge.
    task automatic step(input logic [2:0] empty, input logic [2:0] last, input logic full,
                        input logic exp_gv, input int exp_own, input logic [2:0] exp_pop);
        master_fifo_empty = empty;
        master_last       = last;
        slave_fifo_full   = full;
        #1;
        check_outputs($sformatf("%s c%0d", scn, cyc), exp_gv, exp_own, exp_pop);
        cyc++;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset(input string name);
        ARESETn           = 1'b0;
        master_fifo_empty = 3'b111;
        master_last       = 3'b000;
        slave_fifo_full   = 1'b0;
        master_slave_dest = 3'b111;
        master_weight     = {4'd1, 4'd1, 4'd1};
        scn               = name;
        cyc               = 0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ARESETn           = 1'b0;
        master_fifo_empty = 3'b000;
        master_last       = 3'b000;
        slave_fifo_full   = 1'b0;
        master_slave_dest = 3'b111;
        master_weight     = {4'd1, 4'd1, 4'd1};
        #2;
        check_outputs("reset", 1'b0, 0, 3'b000);
        check("reset owner", 32'(grant_master_number), 32'd0);

        // 4-beat M0 burst; M1 is non-empty but targets the other slave and is never granted.
        do_reset("burst4");
        master_slave_dest[1] = 1'b0;
        step(3'b110, 3'b000, 1'b0, 1'b0, 0, 3'b000);
        step(3'b110, 3'b000, 1'b0, 1'b1, 0, 3'b001);
        step(3'b110, 3'b000, 1'b0, 1'b1, 0, 3'b001);
        step(3'b110, 3'b000, 1'b0, 1'b1, 0, 3'b001);
        step(3'b110, 3'b001, 1'b0, 1'b1, 0, 3'b001);
        step(3'b101, 3'b000, 1'b0, 1'b0, 0, 3'b000);
        step(3'b101, 3'b000, 1'b0, 1'b0, 0, 3'b000);

        // Weights 1 and 0 (treated as 1), single-beat transactions: 0,1,0,1 with one idle gap.
        do_reset("alt");
        master_weight[1] = 4'd0;
        for (int r = 0; r < 2; r++) begin
            step(3'b100, 3'b011, 1'b0, 1'b0, 0, 3'b000);
            step(3'b100, 3'b011, 1'b0, 1'b1, 0, 3'b001);
            step(3'b100, 3'b011, 1'b0, 1'b0, 0, 3'b000);
            step(3'b100, 3'b011, 1'b0, 1'b1, 1, 3'b010);
        end

        // Weights M0=3, M1=1: 0,0,0,1,0,0,0,1.
        do_reset("wrr");
        master_weight[0] = 4'd3;
        for (int r = 0; r < 2; r++) begin
            step(3'b100, 3'b011, 1'b0, 1'b0, 0, 3'b000);
            for (int b = 0; b < 3; b++) step(3'b100, 3'b011, 1'b0, 1'b1, 0, 3'b001);
            step(3'b100, 3'b011, 1'b0, 1'b0, 0, 3'b000);
            step(3'b100, 3'b011, 1'b0, 1'b1, 1, 3'b010);
        end

        // Credit left but no further request the cycle after the end: release, rr_ptr moves to 1.
        do_reset("nofollow");
        master_weight[0] = 4'd3;
        step(3'b110, 3'b001, 1'b0, 1'b0, 0, 3'b000);
        step(3'b110, 3'b001, 1'b0, 1'b1, 0, 3'b001);
        step(3'b111, 3'b000, 1'b0, 1'b1, 0, 3'b000);
        step(3'b100, 3'b011, 1'b0, 1'b0, 0, 3'b000);
        step(3'b100, 3'b011, 1'b0, 1'b1, 1, 3'b010);

        // Owner FIFO empty for 2 cycles mid-burst while M1 requests: grant held, then resumes.
        do_reset("gap");
        step(3'b100, 3'b000, 1'b0, 1'b0, 0, 3'b000);
        step(3'b100, 3'b000, 1'b0, 1'b1, 0, 3'b001);
        step(3'b101, 3'b000, 1'b0, 1'b1, 0, 3'b000);
        step(3'b101, 3'b000, 1'b0, 1'b1, 0, 3'b000);
        step(3'b100, 3'b000, 1'b0, 1'b1, 0, 3'b001);
        step(3'b100, 3'b001, 1'b0, 1'b1, 0, 3'b001);
        step(3'b100, 3'b000, 1'b0, 1'b0, 0, 3'b000);
        step(3'b100, 3'b000, 1'b0, 1'b1, 1, 3'b010);

        // Slave FIFO full for 5 cycles mid-burst: no pops, owner unchanged, remaining beats follow.
        do_reset("full");
        step(3'b110, 3'b000, 1'b0, 1'b0, 0, 3'b000);
        step(3'b110, 3'b000, 1'b0, 1'b1, 0, 3'b001);
        for (int f = 0; f < 5; f++) step(3'b110, 3'b000, 1'b1, 1'b1, 0, 3'b000);
        step(3'b110, 3'b000, 1'b0, 1'b1, 0, 3'b001);
        step(3'b110, 3'b001, 1'b0, 1'b1, 0, 3'b001);
        step(3'b111, 3'b000, 1'b0, 1'b0, 0, 3'b000);

        // Reset mid-burst: outputs drop at once; afterwards M2 wins from rr_ptr 0 and the pointer wraps.
        do_reset("rstmid");
        step(3'b010, 3'b000, 1'b0, 1'b0, 0, 3'b000);
        step(3'b010, 3'b000, 1'b0, 1'b1, 0, 3'b001);
        #2;
        ARESETn = 1'b0;
        #1;
        check_outputs("rstmid async", 1'b0, 0, 3'b000);
        check("rstmid async owner", 32'(grant_master_number), 32'd0);
        master_fifo_empty = 3'b111;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        cyc = 0;
        step(3'b011, 3'b100, 1'b0, 1'b0, 0, 3'b000);
        step(3'b011, 3'b100, 1'b0, 1'b1, 2, 3'b100);
        step(3'b000, 3'b111, 1'b0, 1'b0, 0, 3'b000);
        step(3'b000, 3'b111, 1'b0, 1'b1, 0, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
